ingress_loader: RTL
===================

# ingress_loader

Host-to-switch ingress path and the write-side counterpart of the result buffer's host read port. The host pushes packet words over an Avalon-MM slave write interface into three per-port FIFOs. Each FIFO streams its words to the matching switch input port over a valid/ready handshake, gated by a host-written enable register. A saturating drop counter records every push rejected because its FIFO was full.

## Interface
Parameters:
- DEPTH, 16, entries per port FIFO; must be a power of two, at least 2
- AW, $clog2(DEPTH), FIFO pointer width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- chipselect  in  1  Avalon slave select
- write  in  1  Avalon write strobe
- address  in  4  register index
- byteenable  in  4  byte lanes
- writedata  in  32  write data
- data1, data2, data3  out  32  FIFO head word for switch port n
- valid1, valid2, valid3  out  1  head word for port n is presented
- ready1, ready2, ready3  in  1  switch port n accepts the word
- count1, count2, count3  out  AW+1  FIFO occupancy, 0..DEPTH
- drop_count  out  8  saturating count of pushes rejected because the FIFO was full

## Operation
- A write cycle is chipselect && write. Any write with byteenable != 4'hF is ignored with no side effects.
- Address 1/2/3: push writedata into FIFO 1/2/3.
- Address 5: enable register, en[2:0] <= writedata[2:0]. Bit n-1 enables streaming on port n.
- Address 6: flush. For each set bit of writedata[2:0], that FIFO is emptied: pointers and count cleared.
- All other addresses: the write is ignored.
- Each FIFO is a circular buffer with wrptr and rdptr (AW bits each, wrapping from DEPTH-1 to 0) and count (AW+1 bits).
- Push acceptance:
  - A push is accepted when count < DEPTH, or when a pop happens on the same port in the same cycle.
  - When neither holds, the push is discarded and drop_count increments. drop_count saturates at 255.
- Pop: on each edge with validn && readyn, rdptr advances and count decrements.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Value 0 is an ordinary data word, accepted and streamed like any other.
- Presentation state per port: IDLE (validn = 0) and SHOW (validn = 1).
  - IDLE -> SHOW when count != 0 and en[n-1] = 1.
  - SHOW -> IDLE on a pop that leaves count = 0, or on a pop while en[n-1] = 0.
  - SHOW -> IDLE on a flush of that port.
  - SHOW -> SHOW on a pop while count remains non-zero and en[n-1] = 1.
- Once validn is high, datan stays stable and validn stays high until the pop. Clearing the enable never withdraws a presented word. Only flush withdraws a presented word.
- datan = mem[rdptr] while validn = 1, and 32'h0 otherwise.
- Flush on the same edge as a push to that port: flush wins. The push is discarded and is not counted as a drop.
- Flush on the same edge as a pop on that port: the FIFO ends empty.

## Timing
- Reset values:
  - All FIFOs empty.
  - en = 3'b000.
  - Every valid output = 0, every data output = 0, every count output = 0, drop_count = 0.
  - FIFO storage is not reset.
- Reset is asynchronous assert and synchronous deassert. Reset mid-stream discards all queued words immediately.
- Push latency: a push accepted at edge t into an empty, enabled FIFO gives validn = 1 after edge t. countn updates after edge t.
- Handshake: a transfer occurs at an edge where validn && readyn. The next word is presented in the cycle after that edge, so back-to-back transfers run one per cycle.
- The enable register takes effect after its write edge. An IDLE port with queued words raises validn one edge after en is set.
- No path from readyn to any output is combinational within the same cycle. Outputs change only after clock edges.

## Test plan
- Reset, write en = 3'b001, push 32'h1, 32'h2, 32'h3 to address 1 with ready1 = 1 -> valid1 rises the cycle after the first push; data1 shows 1, 2, 3 on consecutive accepted edges; count1 returns to 0.
- With en = 0, push DEPTH+2 words to port 2 -> count2 = DEPTH and drop_count = 2. Then enable port 2 with ready2 = 1 -> exactly DEPTH words come out in order and the pointers wrap correctly.
- Port 3 full with a pop and a push on the same edge -> push accepted, count3 stays DEPTH, drop_count unchanged.
- Port 1 presenting with ready1 = 0, then write en = 0 -> valid1 and data1 held. Assert ready1 -> one pop occurs, then valid1 = 0 while count1 > 0.
- Flush port 2 on the same edge as a push to port 2 while valid2 = 1 -> count2 = 0, valid2 = 0, data2 = 0, drop_count unchanged.
- Push with byteenable = 4'h3, then a write to address 9 -> no state change. Pulse reset_n low mid-stream -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/ingress_loader_if.sv
// Host write bus and per-port streaming handshake of the ingress loader.
// The slave modport is the loader's side; the master modport is the host/switch side.
interface ingress_loader_if #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic        chipselect;
  logic        write;
  logic [3:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;

  logic [31:0] data1, data2, data3;
  logic        valid1, valid2, valid3;
  logic        ready1, ready2, ready3;
  logic [AW:0] count1, count2, count3;
  logic [7:0]  drop_count;

  modport slave (
    input  chipselect, write, address, byteenable, writedata,
    input  ready1, ready2, ready3,
    output data1, data2, data3,
    output valid1, valid2, valid3,
    output count1, count2, count3,
    output drop_count
  );

  modport master (
    output chipselect, write, address, byteenable, writedata,
    output ready1, ready2, ready3,
    input  data1, data2, data3,
    input  valid1, valid2, valid3,
    input  count1, count2, count3,
    input  drop_count
  );
endinterface

// File: rtl/ingress_loader.sv
// Host-to-switch ingress: three circular FIFOs filled by host register writes,
// each streamed to its switch port over valid/ready once enabled.
module ingress_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  ingress_loader_if.slave  bus
);

  typedef enum logic {IDLE, SHOW} state_e;

  localparam logic [3:0]  ADDR_EN    = 4'd5;
  localparam logic [3:0]  ADDR_FLUSH = 4'd6;
  localparam logic [AW:0] FULL       = (AW + 1)'(DEPTH);

  logic          wr_ok;
  logic [2:0]    ready, push_req, flush, pop, push_acc, drop;
  logic [2:0]    en_q, en_d;
  logic [7:0]    drop_q, drop_d;
  state_e        state_q [3];
  state_e        state_d [3];
  logic [AW-1:0] wrptr_q [3];
  logic [AW-1:0] wrptr_d [3];
  logic [AW-1:0] rdptr_q [3];
  logic [AW-1:0] rdptr_d [3];
  logic [AW:0]   count_q [3];
  logic [AW:0]   count_d [3];
  logic [31:0]   mem_q   [3][DEPTH];
  logic [31:0]   data    [3];
  logic [2:0]    valid;

  assign wr_ok = bus.chipselect && bus.write && (bus.byteenable == 4'hF);
  assign ready = {bus.ready3, bus.ready2, bus.ready1};

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    en_d   = en_q;
    drop_d = drop_q;
    if (wr_ok && bus.address == ADDR_EN) en_d = bus.writedata[2:0];

    for (int p = 0; p < 3; p++) begin
      push_req[p] = wr_ok && (bus.address == 4'(p + 1));
      flush[p]    = wr_ok && (bus.address == ADDR_FLUSH) && bus.writedata[p];
      pop[p]      = (state_q[p] == SHOW) && ready[p];
      push_acc[p] = push_req[p] && !flush[p] && ((count_q[p] != FULL) || pop[p]);
      drop[p]     = push_req[p] && !flush[p] && !((count_q[p] != FULL) || pop[p]);

      wrptr_d[p] = wrptr_q[p];
      rdptr_d[p] = rdptr_q[p];
      count_d[p] = count_q[p];
      state_d[p] = state_q[p];

      if (flush[p]) begin
        wrptr_d[p] = '0;
        rdptr_d[p] = '0;
        count_d[p] = '0;
        state_d[p] = IDLE;
      end else begin
        if (push_acc[p]) wrptr_d[p] = wrptr_q[p] + AW'(1);
        if (pop[p])      rdptr_d[p] = rdptr_q[p] + AW'(1);
        case ({push_acc[p], pop[p]})
          2'b10:   count_d[p] = count_q[p] + (AW + 1)'(1);
          2'b01:   count_d[p] = count_q[p] - (AW + 1)'(1);
          default: count_d[p] = count_q[p];
        endcase

        // A presented word is only retired by a pop; the enable gates new presentations.
        case (state_q[p])
          IDLE:    if (count_d[p] != '0 && en_q[p]) state_d[p] = SHOW;
          SHOW:    if (pop[p] && (count_d[p] == '0 || !en_q[p])) state_d[p] = IDLE;
          default: state_d[p] = IDLE;
        endcase
      end
    end

    if (|drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q   <= '0;
      drop_q <= '0;
      for (int p = 0; p < 3; p++) begin
        state_q[p] <= IDLE;
        wrptr_q[p] <= '0;
        rdptr_q[p] <= '0;
        count_q[p] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops sample together.
      en_q   <= en_d;
      drop_q <= drop_d;
      for (int p = 0; p < 3; p++) begin
        state_q[p] <= state_d[p];
        wrptr_q[p] <= wrptr_d[p];
        rdptr_q[p] <= rdptr_d[p];
        count_q[p] <= count_d[p];
      end
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 3; p++) begin
      if (push_acc[p]) mem_q[p][wrptr_q[p]] <= bus.writedata;
    end
  end

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      valid[p] = (state_q[p] == SHOW);
      data[p]  = valid[p] ? mem_q[p][rdptr_q[p]] : 32'h0;
    end
  end

  assign bus.valid1     = valid[0];
  assign bus.valid2     = valid[1];
  assign bus.valid3     = valid[2];
  assign bus.data1      = data[0];
  assign bus.data2      = data[1];
  assign bus.data3      = data[2];
  assign bus.count1     = count_q[0];
  assign bus.count2     = count_q[1];
  assign bus.count3     = count_q[2];
  assign bus.drop_count = drop_q;

endmodule
